reg_dump_ctrl: RTL

Register-file access engine that sits on the initiator side of the 8×8 register file's port. It drives the read address, the write address, the write data and the write enable. On a `start` pulse it either dumps all registers, in address order, onto a valid/ready output stream, or loads all registers from a valid/ready input stream. It is used for debug/state save-restore and exercises the file's combinational read and clocked write paths.

---
 rtl/reg_dump_pkg.sv | 18 +
 rtl/reg_dump_csum.sv | 25 ++
 rtl/reg_dump_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared constants and FSM encoding for the register-file dump/load engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_dump_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DUMP_RD,
        ST_DUMP_WAIT,
        ST_LOAD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/reg_dump_csum.sv
// Running byte-sum of dumped register values, cleared at the start of each operation.
// Latency: sum reflects an add one cycle after add_en.
// Backpressure: none; the caller gates add_en.
module reg_dump_csum #(
    parameter int DATA_W = reg_dump_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_dat,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + add_dat;
        end
    end

endmodule

// File: rtl/reg_dump_ctrl.sv
// Walks the register file: dumps every register onto a valid/ready stream or loads it from one.
// Latency: dump 2*NUM_REGS+1 cycles start-to-done (+2 with REG_DUMP_CSUM_EN), load NUM_REGS+1 at full rate.
// Backpressure: dump beats hold while dump_ready is low; load_ready is high for the whole LOAD state.
module reg_dump_ctrl #(
    parameter int DATA_W   = reg_dump_pkg::DATA_W,
    parameter int ADDR_W   = reg_dump_pkg::ADDR_W,
    parameter int NUM_REGS = reg_dump_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic [ADDR_W-1:0] rd_addr1,
    input  logic [DATA_W-1:0] rd_data1,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              dump_valid,
    input  logic              dump_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              busy,
    output logic              done
);
    import reg_dump_pkg::*;

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_REGS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    assign rd_addr1   = (state == ST_DUMP_RD) ? cnt[ADDR_W-1:0] : '0;
    assign load_ready = (state == ST_LOAD);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

`ifdef REG_DUMP_CSUM_EN
    // The checksum beat reuses DUMP_RD with cnt one past the last register.
    localparam logic [CNT_W-1:0] CSUM_IDX = CNT_W'(NUM_REGS);

    logic [DATA_W-1:0] csum;
    logic              csum_clr;
    logic              csum_add;

    assign csum_clr = (state == ST_IDLE) && start;
    assign csum_add = (state == ST_DUMP_RD) && (cnt != CSUM_IDX);

    reg_dump_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk     (clk),
        .reset   (reset),
        .clr     (csum_clr),
        .add_en  (csum_add),
        .add_dat (rd_data1),
        .sum     (csum)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            dump_data  <= '0;
            dump_addr  <= '0;
            dump_last  <= 1'b0;
            dump_valid <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        state <= mode ? ST_LOAD : ST_DUMP_RD;
                    end
                end
                ST_DUMP_RD: begin
                    dump_valid <= 1'b1;
                    dump_data  <= rd_data1;
                    dump_addr  <= cnt[ADDR_W-1:0];
`ifdef REG_DUMP_CSUM_EN
                    dump_last  <= 1'b0;
                    if (cnt == CSUM_IDX) begin
                        dump_data <= csum;
                        dump_addr <= '0;
                        dump_last <= 1'b1;
                    end
`else
                    dump_last  <= (cnt == LAST_IDX);
`endif
                    state      <= ST_DUMP_WAIT;
                end
                ST_DUMP_WAIT: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (dump_last) begin
                            state <= ST_DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= ST_DUMP_RD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt[ADDR_W-1:0];
                        wr_data <= load_data;
                        cnt     <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
